// File: rtl/cpu_status_reg_if.sv
// Bundle between the control sequencer / ALU and the processor status register.
// Master drives control, ALU flags and interrupt lines; slave returns P, branch and interrupt status.
// Ports: ALU flags, update enables, flag_op, BIT/PLP loads, branch_cond, irq_n/nmi_n, int_ack/int_nmi,
//        p_reg, p_push, carry_flag, branch_taken, irq_pending, nmi_pending (+ decimal_mode with DECIMAL_MODE_EN).
interface cpu_status_reg_if;
   logic       alu_carry;
   logic       alu_overflow;
   logic       alu_negative;
   logic       alu_zero;
   logic       upd_nz;
   logic       upd_c;
   logic       upd_v;
   logic [2:0] flag_op;
   logic       bit_load;
   logic [7:0] bit_mem;
   logic       plp_load;
   logic [7:0] plp_data;
   logic       brk_push;
   logic [2:0] branch_cond;
   logic       irq_n;
   logic       nmi_n;
   logic       int_ack;
   logic       int_nmi;
   logic [7:0] p_reg;
   logic [7:0] p_push;
   logic       carry_flag;
   logic       branch_taken;
   logic       irq_pending;
   logic       nmi_pending;
`ifdef DECIMAL_MODE_EN
   logic       decimal_mode;
`endif

   modport master (
      output alu_carry, alu_overflow, alu_negative, alu_zero,
      output upd_nz, upd_c, upd_v, flag_op,
      output bit_load, bit_mem, plp_load, plp_data,
      output brk_push, branch_cond,
      output irq_n, nmi_n, int_ack, int_nmi,
      input  p_reg, p_push, carry_flag, branch_taken,
`ifdef DECIMAL_MODE_EN
      input  decimal_mode,
`endif
      input  irq_pending, nmi_pending
   );

   modport slave (
      input  alu_carry, alu_overflow, alu_negative, alu_zero,
      input  upd_nz, upd_c, upd_v, flag_op,
      input  bit_load, bit_mem, plp_load, plp_data,
      input  brk_push, branch_cond,
      input  irq_n, nmi_n, int_ack, int_nmi,
      output p_reg, p_push, carry_flag, branch_taken,
`ifdef DECIMAL_MODE_EN
      output decimal_mode,
`endif
      output irq_pending, nmi_pending
   );
endinterface

// File: rtl/cpu_status_reg.sv
// Processor status (P) register stage downstream of the 8-bit ALU: flag capture,
// flag instructions, BIT, PLP, push formatting, branch evaluation and IRQ/NMI pending state.
// Ports: clk, rst (sync, active high), bus (cpu_status_reg_if.slave).
// Build option: DECIMAL_MODE_EN makes D a real flag and adds bus.decimal_mode;
// without it D is hardwired to 0.
module cpu_status_reg #(
   parameter logic [7:0] RESET_P = 8'h24
) (
   input logic             clk,
   input logic             rst,
   cpu_status_reg_if.slave bus
);

   logic r_n;
   logic r_v;
   logic r_i;
   logic r_z;
   logic r_c;
`ifdef DECIMAL_MODE_EN
   logic r_d;
`endif
   logic r_irq_q;
   logic r_nmi_prev;
   logic r_nmi_pend;

   logic w_d;
   logic w_n_nxt;
   logic w_v_nxt;
   logic w_i_nxt;
   logic w_z_nxt;
   logic w_c_nxt;
`ifdef DECIMAL_MODE_EN
   logic w_d_nxt;
`endif

   logic w_op_clc;
   logic w_op_sec;
   logic w_op_cli;
   logic w_op_sei;
   logic w_op_clv;
   logic w_op_cld;
   logic w_op_sed;

   logic w_nmi_edge;
   logic w_nmi_ack;
   logic w_br_flag;
   logic w_unused;

   // flag_op decode
   always_comb begin
      w_op_clc = 1'b0;
      w_op_sec = 1'b0;
      w_op_cli = 1'b0;
      w_op_sei = 1'b0;
      w_op_clv = 1'b0;
      w_op_cld = 1'b0;
      w_op_sed = 1'b0;
      case (bus.flag_op)
         3'd1:    w_op_clc = 1'b1;
         3'd2:    w_op_sec = 1'b1;
         3'd3:    w_op_cli = 1'b1;
         3'd4:    w_op_sei = 1'b1;
         3'd5:    w_op_clv = 1'b1;
         3'd6:    w_op_cld = 1'b1;
         3'd7:    w_op_sed = 1'b1;
         default: ;
      endcase
   end

   // Per-flag next state: PLP > flag_op > BIT > ALU > int_ack > hold
   always_comb begin
      w_c_nxt = r_c;
      if (bus.plp_load)
         w_c_nxt = bus.plp_data[0];
      else if (w_op_clc)
         w_c_nxt = 1'b0;
      else if (w_op_sec)
         w_c_nxt = 1'b1;
      else if (bus.upd_c)
         w_c_nxt = bus.alu_carry;
   end

   always_comb begin
      w_z_nxt = r_z;
      if (bus.plp_load)
         w_z_nxt = bus.plp_data[1];
      else if (bus.bit_load || bus.upd_nz)
         w_z_nxt = bus.alu_zero;
   end

   always_comb begin
      w_i_nxt = r_i;
      if (bus.plp_load)
         w_i_nxt = bus.plp_data[2];
      else if (w_op_cli)
         w_i_nxt = 1'b0;
      else if (w_op_sei)
         w_i_nxt = 1'b1;
      else if (bus.int_ack)
         w_i_nxt = 1'b1;
   end

`ifdef DECIMAL_MODE_EN
   always_comb begin
      w_d_nxt = r_d;
      if (bus.plp_load)
         w_d_nxt = bus.plp_data[3];
      else if (w_op_cld)
         w_d_nxt = 1'b0;
      else if (w_op_sed)
         w_d_nxt = 1'b1;
   end
   assign w_d = r_d;
   assign w_unused = ^{bus.plp_data[5:4]};
`else
   assign w_d = 1'b0;
   assign w_unused = ^{bus.plp_data[5:3], w_op_cld, w_op_sed};
`endif

   always_comb begin
      w_v_nxt = r_v;
      if (bus.plp_load)
         w_v_nxt = bus.plp_data[6];
      else if (w_op_clv)
         w_v_nxt = 1'b0;
      else if (bus.bit_load)
         w_v_nxt = bus.bit_mem[6];
      else if (bus.upd_v)
         w_v_nxt = bus.alu_overflow;
   end

   always_comb begin
      w_n_nxt = r_n;
      if (bus.plp_load)
         w_n_nxt = bus.plp_data[7];
      else if (bus.bit_load)
         w_n_nxt = bus.bit_mem[7];
      else if (bus.upd_nz)
         w_n_nxt = bus.alu_negative;
   end

   // Falling NMI edge; an edge coinciding with an ack re-arms pending
   assign w_nmi_edge = r_nmi_prev & ~bus.nmi_n;
   assign w_nmi_ack  = bus.int_ack & bus.int_nmi;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_n        <= RESET_P[7];
         r_v        <= RESET_P[6];
         r_i        <= RESET_P[2];
         r_z        <= RESET_P[1];
         r_c        <= RESET_P[0];
`ifdef DECIMAL_MODE_EN
         r_d        <= RESET_P[3];
`endif
         r_irq_q    <= 1'b0;
         r_nmi_prev <= 1'b1;
         r_nmi_pend <= 1'b0;
      end else begin
         r_n        <= w_n_nxt;
         r_v        <= w_v_nxt;
         r_i        <= w_i_nxt;
         r_z        <= w_z_nxt;
         r_c        <= w_c_nxt;
`ifdef DECIMAL_MODE_EN
         r_d        <= w_d_nxt;
`endif
         r_irq_q    <= ~bus.irq_n;
         r_nmi_prev <= bus.nmi_n;
         r_nmi_pend <= w_nmi_edge | (r_nmi_pend & ~w_nmi_ack);
      end
   end

   // branch_cond[2:1] picks the flag, branch_cond[0] the value that takes it
   always_comb begin
      w_br_flag = r_z;
      case (bus.branch_cond[2:1])
         2'b00:   w_br_flag = r_n;
         2'b01:   w_br_flag = r_v;
         2'b10:   w_br_flag = r_c;
         default: w_br_flag = r_z;
      endcase
   end

   assign bus.p_reg        = {r_n, r_v, 1'b1, 1'b0, w_d, r_i, r_z, r_c};
   assign bus.p_push       = {r_n, r_v, 1'b1, bus.brk_push, w_d, r_i, r_z, r_c};
   assign bus.carry_flag   = r_c;
   assign bus.branch_taken = (w_br_flag == bus.branch_cond[0]);
   assign bus.irq_pending  = r_irq_q & ~r_i;
   assign bus.nmi_pending  = r_nmi_pend;
`ifdef DECIMAL_MODE_EN
   assign bus.decimal_mode = r_d;
`endif

endmodule

// File: tb/tb_cpu_status_reg.sv
// Scoreboard bench for cpu_status_reg: directed sequences then random stimulus,
// checked against a byte-level reference model of the status register.
module tb_cpu_status_reg;

   typedef struct packed {
      logic       rst;
      logic       alu_c;
      logic       alu_v;
      logic       alu_n;
      logic       alu_z;
      logic       upd_nz;
      logic       upd_c;
      logic       upd_v;
      logic [2:0] flag_op;
      logic       bit_load;
      logic [7:0] bit_mem;
      logic       plp_load;
      logic [7:0] plp_data;
      logic       brk_push;
      logic [2:0] branch_cond;
      logic       irq_n;
      logic       nmi_n;
      logic       int_ack;
      logic       int_nmi;
   } stim_t;

   typedef struct packed {
      logic [7:0] p_reg;
      logic [7:0] p_push;
      logic       carry;
      logic       br;
      logic       irq;
      logic       nmi;
      logic       dec;
   } exp_t;

   logic clk;
   logic rst;
   cpu_status_reg_if bus ();

   cpu_status_reg #(.RESET_P(8'h24)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   // Reference model state
   logic [7:0] m_p;
   logic       m_irq_q;
   logic       m_nmi_prev;
   logic       m_nmi_pend;
   logic       m_known = 1'b0;

   // Which P bit each flag_op touches and the value it writes
   int         fidx [8] = '{0, 0, 0, 2, 2, 6, 3, 3};
   logic       fval [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
   // Flag tested by branch_cond[2:1]: N, V, C, Z
   int         bidx [4] = '{7, 6, 0, 1};

`ifdef DECIMAL_MODE_EN
   localparam logic [7:0] KEEP = 8'hEF;
`else
   localparam logic [7:0] KEEP = 8'hE7;
`endif

   function automatic stim_t idle();
      stim_t s;
      s = '0;
      s.irq_n = 1'b1;
      s.nmi_n = 1'b1;
      return s;
   endfunction

   task automatic drive(input stim_t s);
      exp_t       e;
      logic [7:0] np;
      @(posedge clk);
      #1;
      cyc++;
      rst              = s.rst;
      bus.alu_carry    = s.alu_c;
      bus.alu_overflow = s.alu_v;
      bus.alu_negative = s.alu_n;
      bus.alu_zero     = s.alu_z;
      bus.upd_nz       = s.upd_nz;
      bus.upd_c        = s.upd_c;
      bus.upd_v        = s.upd_v;
      bus.flag_op      = s.flag_op;
      bus.bit_load     = s.bit_load;
      bus.bit_mem      = s.bit_mem;
      bus.plp_load     = s.plp_load;
      bus.plp_data     = s.plp_data;
      bus.brk_push     = s.brk_push;
      bus.branch_cond  = s.branch_cond;
      bus.irq_n        = s.irq_n;
      bus.nmi_n        = s.nmi_n;
      bus.int_ack      = s.int_ack;
      bus.int_nmi      = s.int_nmi;
      if (m_known) begin
         e.p_reg  = m_p;
         e.p_push = m_p;
         e.p_push[4] = s.brk_push;
         e.carry  = m_p[0];
         e.br     = (m_p[bidx[s.branch_cond[2:1]]] == s.branch_cond[0]);
         e.irq    = m_irq_q && !m_p[2];
         e.nmi    = m_nmi_pend;
         e.dec    = m_p[3];
         q.push_back(e);
      end
      if (s.rst) begin
         m_p        = 8'h24;
         m_irq_q    = 1'b0;
         m_nmi_prev = 1'b1;
         m_nmi_pend = 1'b0;
         m_known    = 1'b1;
      end else if (m_known) begin
         // Apply sources lowest priority first so higher ones overwrite
         np = m_p;
         if (s.int_ack) np[2] = 1'b1;
         if (s.upd_c) np[0] = s.alu_c;
         if (s.upd_v) np[6] = s.alu_v;
         if (s.upd_nz) begin
            np[7] = s.alu_n;
            np[1] = s.alu_z;
         end
         if (s.bit_load) begin
            np[7] = s.bit_mem[7];
            np[6] = s.bit_mem[6];
            np[1] = s.alu_z;
         end
         if (s.flag_op != 3'd0) np[fidx[s.flag_op]] = fval[s.flag_op];
         if (s.plp_load) np = s.plp_data;
         m_p = (np & KEEP) | 8'h20;
         m_nmi_pend = (m_nmi_prev && !s.nmi_n) ||
                      (m_nmi_pend && !(s.int_ack && s.int_nmi));
         m_nmi_prev = s.nmi_n;
         m_irq_q    = !s.irq_n;
      end
   endtask

   task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, got, exp);
      end
   endtask

   // Monitor: DUT outputs are valid every cycle once reset is known
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("p_reg", bus.p_reg, e.p_reg);
            chk("p_push", bus.p_push, e.p_push);
            chk("carry_flag", {7'd0, bus.carry_flag}, {7'd0, e.carry});
            chk("branch_taken", {7'd0, bus.branch_taken}, {7'd0, e.br});
            chk("irq_pending", {7'd0, bus.irq_pending}, {7'd0, e.irq});
            chk("nmi_pending", {7'd0, bus.nmi_pending}, {7'd0, e.nmi});
`ifdef DECIMAL_MODE_EN
            chk("decimal_mode", {7'd0, bus.decimal_mode}, {7'd0, e.dec});
`endif
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      stim_t s;
      logic  irq_l;
      logic  nmi_l;
      rst = 1'b1;
      s = idle();
      {bus.alu_carry, bus.alu_overflow, bus.alu_negative, bus.alu_zero} = '0;
      {bus.upd_nz, bus.upd_c, bus.upd_v, bus.bit_load, bus.plp_load} = '0;
      bus.flag_op = '0;     bus.bit_mem = '0;     bus.plp_data = '0;
      bus.brk_push = 1'b0;  bus.branch_cond = '0;
      bus.irq_n = 1'b1;     bus.nmi_n = 1'b1;
      bus.int_ack = 1'b0;   bus.int_nmi = 1'b0;

      // Reset, then push image with and without B
      s = idle(); s.rst = 1'b1;
      drive(s);
      drive(s);
      s = idle();
      drive(s);
      s.brk_push = 1'b1;
      drive(s);

      // ALU update of all flags, then branch conditions
      s = idle();
      s.upd_nz = 1'b1; s.upd_c = 1'b1; s.upd_v = 1'b1;
      s.alu_n = 1'b1;  s.alu_z = 1'b0; s.alu_c = 1'b1; s.alu_v = 1'b1;
      drive(s);
      s = idle(); s.branch_cond = 3'b101; drive(s);
      s = idle(); s.branch_cond = 3'b100; drive(s);
      s = idle(); s.branch_cond = 3'b001; drive(s);

      // PLP beats SEC
      s = idle(); s.plp_load = 1'b1; s.plp_data = 8'hFF; s.flag_op = 3'd2;
      drive(s);
      s = idle(); drive(s);

      // BIT
      s = idle(); s.bit_load = 1'b1; s.bit_mem = 8'h40; s.alu_z = 1'b1;
      drive(s);
      s = idle(); drive(s);

      // IRQ held while masked, CLI, then ack
      s = idle(); s.irq_n = 1'b0;
      drive(s); drive(s); drive(s);
      s.flag_op = 3'd3; drive(s);
      s.flag_op = 3'd0; drive(s); drive(s);
      s.int_ack = 1'b1; drive(s);
      s.int_ack = 1'b0; drive(s); drive(s);
      s.irq_n = 1'b1; drive(s);

      // NMI held low, acked, released, re-asserted; edge coinciding with ack
      s = idle(); drive(s);
      s.nmi_n = 1'b0;
      drive(s); drive(s); drive(s);
      s.int_ack = 1'b1; s.int_nmi = 1'b1; drive(s);
      s.int_ack = 1'b0; s.int_nmi = 1'b0;
      for (int i = 0; i < 6; i++) drive(s);
      s.nmi_n = 1'b1; drive(s);
      s.nmi_n = 1'b0; drive(s); drive(s);
      s.nmi_n = 1'b1; drive(s);
      s.nmi_n = 1'b0; s.int_ack = 1'b1; s.int_nmi = 1'b1; drive(s);
      s = idle(); s.nmi_n = 1'b0; drive(s); drive(s);
      s = idle(); s.int_ack = 1'b1; s.int_nmi = 1'b1; drive(s);
      drive(s);

      // Random traffic
      irq_l = 1'b1;
      nmi_l = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         s = idle();
         s.rst         = ($urandom_range(0, 63) == 0);
         s.alu_c       = 1'($urandom);
         s.alu_v       = 1'($urandom);
         s.alu_n       = 1'($urandom);
         s.alu_z       = 1'($urandom);
         s.upd_nz      = 1'($urandom);
         s.upd_c       = 1'($urandom);
         s.upd_v       = 1'($urandom);
         s.flag_op     = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom);
         s.bit_load    = ($urandom_range(0, 7) == 0);
         s.bit_mem     = 8'($urandom);
         s.plp_load    = ($urandom_range(0, 9) == 0);
         s.plp_data    = 8'($urandom);
         s.brk_push    = 1'($urandom);
         s.branch_cond = 3'($urandom);
         if ($urandom_range(0, 7) == 0) irq_l = ~irq_l;
         if ($urandom_range(0, 5) == 0) nmi_l = ~nmi_l;
         s.irq_n       = irq_l;
         s.nmi_n       = nmi_l;
         s.int_ack     = ($urandom_range(0, 7) == 0);
         s.int_nmi     = 1'($urandom);
         drive(s);
      end

      s = idle();
      drive(s);
      @(negedge clk);
      #1;
      chk("queue_drained", 8'(q.size()), 8'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
